// File: rtl/axi_pim_pkg.sv
// Shared constants for the axi_pim slave and its controllers: AXI encodings,
// controller state codes and the beat-size helper.
package axi_pim_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef logic [2:0] ctrl_state_t;

  localparam ctrl_state_t ST_IDLE = 3'd0;
  localparam ctrl_state_t ST_AW   = 3'd1;
  localparam ctrl_state_t ST_W    = 3'd2;
  localparam ctrl_state_t ST_B    = 3'd3;
  localparam ctrl_state_t ST_AR   = 3'd4;
  localparam ctrl_state_t ST_R    = 3'd5;
  localparam ctrl_state_t ST_DONE = 3'd6;

  // AXI size field: log2 of the bytes per beat.
  function automatic logic [2:0] axi_size(input int bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/axi_pim_ctrl_if.sv
// AXI4 bus between a burst master and the axi_pim slave port.
interface axi_pim_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int ID_WIDTH   = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_pim_ctrl.sv
// Command-driven AXI4 burst master for axi_pim: one {write|read, addr, len}
// command becomes one full AW/W/B or AR/R transaction. Write beats come from
// the wr_* stream, read beats leave on the rd_* stream, both pass-through.
module axi_pim_ctrl
  import axi_pim_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int AXI_ID     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,

  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,

  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,

  output logic                  busy,
  output logic                  done,
  output logic                  err,

  axi_pim_ctrl_if.master        m_axi
);

  localparam logic [ID_WIDTH-1:0] ID_C = ID_WIDTH'(AXI_ID);
  localparam logic [2:0]          SIZE = axi_size(STRB_WIDTH);

  ctrl_state_t           state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic                  err_acc;
  logic                  aw_q;
  logic                  ar_q;

  logic last_beat;
  logic w_hs;
  logic r_hs;

  // The 8-bit compare is exact, so len=255 gives 256 beats without wrap trouble.
  assign last_beat = (beat_cnt == len_q);
  assign w_hs      = m_axi.wvalid & m_axi.wready;
  assign r_hs      = m_axi.rvalid & m_axi.rready;

  // Main FSM, beat counter and sticky error; reset aborts with no done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      err_acc  <= 1'b0;
      aw_q     <= 1'b0;
      ar_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            beat_cnt <= '0;
            err_acc  <= 1'b0;
            if (cmd_write) begin
              state <= ST_AW;
              aw_q  <= 1'b1;
            end else begin
              state <= ST_AR;
              ar_q  <= 1'b1;
            end
          end
        end
        ST_AW: begin
          if (m_axi.awready) begin
            aw_q  <= 1'b0;
            state <= ST_W;
          end
        end
        ST_W: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) state <= ST_B;
          end
        end
        ST_B: begin
          if (m_axi.bvalid) begin
            err_acc <= err_acc | (m_axi.bresp != AXI_RESP_OKAY) | (m_axi.bid != ID_C);
            state   <= ST_DONE;
          end
        end
        ST_AR: begin
          if (m_axi.arready) begin
            ar_q  <= 1'b0;
            state <= ST_R;
          end
        end
        ST_R: begin
          // An early rlast ends the burst; a late one keeps us draining.
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            err_acc  <= err_acc | (m_axi.rresp != AXI_RESP_OKAY) | (m_axi.rlast != last_beat);
            if (m_axi.rlast) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Host-side status; cmd_ready is also held low while reset is asserted.
  assign cmd_ready = rst_n & (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign err       = done & err_acc;

  // Write data is a straight pass-through of the source stream while in W.
  assign wr_ready      = (state == ST_W) & m_axi.wready;
  assign m_axi.wvalid  = (state == ST_W) & wr_valid;
  assign m_axi.wdata   = wr_data;
  assign m_axi.wstrb   = {STRB_WIDTH{1'b1}};
  assign m_axi.wlast   = (state == ST_W) & last_beat;
  assign m_axi.bready  = (state == ST_B);

  // Read data is a straight pass-through to the sink stream while in R.
  assign rd_valid      = (state == ST_R) & m_axi.rvalid;
  assign rd_data       = m_axi.rdata;
  assign m_axi.rready  = (state == ST_R) & rd_ready;

  // Address channels: fixed ID/size/burst, the slave does the INCR stepping.
  assign m_axi.awid    = ID_C;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = SIZE;
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'd0;
  assign m_axi.awprot  = 3'd0;
  assign m_axi.awvalid = aw_q;

  assign m_axi.arid    = ID_C;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arsize  = SIZE;
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'd0;
  assign m_axi.arprot  = 3'd0;
  assign m_axi.arvalid = ar_q;

endmodule

// File: tb/tb_axi_pim_ctrl.sv
// Bench for axi_pim_ctrl: a small word-addressed AXI slave model, a table of
// command vectors with expected latency/err, queues of expected beats, and
// hand sequences for busy blocking and mid-burst reset.
module tb_axi_pim_ctrl;
  import axi_pim_pkg::*;

  localparam int DW     = 32;
  localparam int AW     = 8;
  localparam int IW     = 8;
  localparam int BUDGET = 600;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_ready;
  logic          busy, done, err;

  always #5 clk = ~clk;

  axi_pim_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) axi ();

  axi_pim_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .AXI_ID(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .err(err),
    .m_axi(axi.master)
  );

  // ---------------- slave model ----------------
  logic [31:0] mem [256];
  logic [7:0]  s_wbase, s_wcnt, s_rbase, s_rcnt, w_idx, r_idx;
  logic        b_pend, r_act, s_wready;
  logic [1:0]  bresp_cfg;
  int          rlast_at;

  assign w_idx       = s_wbase + s_wcnt;
  assign r_idx       = s_rbase + s_rcnt;
  assign axi.awready = 1'b1;
  assign axi.arready = 1'b1;
  assign axi.wready  = s_wready;
  assign axi.bvalid  = b_pend;
  assign axi.bresp   = bresp_cfg;
  assign axi.bid     = 8'd1;
  assign axi.rvalid  = r_act;
  assign axi.rdata   = mem[r_idx];
  assign axi.rresp   = 2'b00;
  assign axi.rid     = 8'd1;
  assign axi.rlast   = r_act && (int'(s_rcnt) == rlast_at);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_wbase <= '0; s_wcnt <= '0; s_rbase <= '0; s_rcnt <= '0;
      b_pend  <= 1'b0; r_act <= 1'b0;
    end else begin
      if (axi.awvalid && axi.awready) begin
        s_wbase <= {2'b00, axi.awaddr[7:2]};
        s_wcnt  <= '0;
      end
      if (axi.wvalid && axi.wready) begin
        mem[w_idx] <= axi.wdata;
        s_wcnt     <= s_wcnt + 8'd1;
        if (axi.wlast) b_pend <= 1'b1;
      end
      if (axi.bvalid && axi.bready) b_pend <= 1'b0;
      if (axi.arvalid && axi.arready) begin
        s_rbase <= {2'b00, axi.araddr[7:2]};
        s_rcnt  <= '0;
        r_act   <= 1'b1;
      end
      if (axi.rvalid && axi.rready) begin
        s_rcnt <= s_rcnt + 8'd1;
        if (axi.rlast) r_act <= 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_wq[$];
  logic [31:0] exp_rq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_pop_w(input logic [31:0] act);
    if (exp_wq.size() == 0) begin
      checks++; failures++;
      $display("FAIL wdata_extra actual=%0h expected=none", act);
    end else chk("wdata", act, exp_wq.pop_front());
  endtask

  task automatic chk_pop_r(input logic [31:0] act);
    if (exp_rq.size() == 0) begin
      checks++; failures++;
      $display("FAIL rd_data_extra actual=%0h expected=none", act);
    end else chk("rd_data", act, exp_rq.pop_front());
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [7:0]  len;
    logic [31:0] base;
    bit          gap;      // stall wr_valid and wready at intervals
    bit          tog;      // rd_ready every other cycle
    logic [1:0]  bresp;
    int          rlast_at; // -1: slave puts rlast on beat len
    bit          exp_err;
    int          exp_cyc;  // cycles from accept to done, -1: not checked
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input vec_t v);
    int  wbeat;
    bit  seen;
    int  nbeats;
    wbeat = 0;
    seen  = 0;
    bresp_cfg = v.bresp;
    rlast_at  = (v.rlast_at < 0) ? int'(v.len) : v.rlast_at;
    if (v.wr) begin
      for (int i = 0; i <= int'(v.len); i++) exp_wq.push_back(v.base + 32'(i));
    end else begin
      nbeats = rlast_at + 1;
      for (int i = 0; i < nbeats; i++) exp_rq.push_back(v.base + 32'(i));
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
    #1 chk("cmd_ready_idle", cmd_ready, 1'b1);
    @(posedge clk);
    for (int cyc = 1; cyc <= BUDGET && !seen; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      wr_valid  = v.wr && (wbeat <= int'(v.len)) && !(v.gap && (cyc % 3 == 1));
      wr_data   = v.base + 32'(wbeat);
      s_wready  = !(v.gap && (cyc % 4 == 2));
      rd_ready  = v.tog ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (axi.awvalid && axi.awready) begin
        chk("awaddr", axi.awaddr, v.addr);
        chk("awlen", axi.awlen, v.len);
        chk("awsize", axi.awsize, 3'd2);
        chk("awburst", axi.awburst, 2'b01);
        chk("awid", axi.awid, 8'd1);
      end
      if (axi.arvalid && axi.arready) begin
        chk("araddr", axi.araddr, v.addr);
        chk("arlen", axi.arlen, v.len);
        chk("arsize", axi.arsize, 3'd2);
      end
      if (axi.wvalid && axi.wready) begin
        chk("wlast", axi.wlast, (wbeat == int'(v.len)));
        chk("wstrb", axi.wstrb, 4'hF);
        chk_pop_w(axi.wdata);
        wbeat++;
      end
      if (rd_valid && rd_ready) chk_pop_r(rd_data);
      if (done) begin
        seen = 1;
        chk("done_err", err, v.exp_err);
        if (v.exp_cyc >= 0) chk("latency", cyc, v.exp_cyc);
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=none expected=done within %0d", BUDGET);
    end else begin
      @(negedge clk);
      #1 chk("done_single_pulse", done, 1'b0);
      chk("cmd_ready_after", cmd_ready, 1'b1);
    end
    chk("wq_left", exp_wq.size(), 0);
    chk("rq_left", exp_rq.size(), 0);
    exp_wq.delete();
    exp_rq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    bit seen;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 0; rd_ready = 0;
    s_wready = 1; bresp_cfg = 2'b00; rlast_at = 0;

    vecs[0]  = '{1'b1, 8'h00, 8'd3,   32'hDEADBEEF, 1'b0, 1'b0, 2'b00, -1, 1'b0, 7};
    vecs[1]  = '{1'b0, 8'h00, 8'd3,   32'hDEADBEEF, 1'b0, 1'b0, 2'b00, -1, 1'b0, 6};
    vecs[2]  = '{1'b0, 8'h00, 8'd1,   32'hDEADBEEF, 1'b0, 1'b0, 2'b00,  2, 1'b1, 5};
    vecs[3]  = '{1'b1, 8'h40, 8'd3,   32'h10000000, 1'b1, 1'b0, 2'b00, -1, 1'b0, -1};
    vecs[4]  = '{1'b0, 8'h40, 8'd3,   32'h10000000, 1'b0, 1'b1, 2'b00, -1, 1'b0, -1};
    vecs[5]  = '{1'b1, 8'h80, 8'd0,   32'hA5A50000, 1'b0, 1'b0, 2'b10, -1, 1'b1, 4};
    vecs[6]  = '{1'b0, 8'h80, 8'd0,   32'hA5A50000, 1'b0, 1'b0, 2'b00, -1, 1'b0, 3};
    vecs[7]  = '{1'b0, 8'h00, 8'd3,   32'hDEADBEEF, 1'b0, 1'b0, 2'b00,  1, 1'b1, 4};
    vecs[8]  = '{1'b1, 8'hC0, 8'd15,  32'h55000000, 1'b0, 1'b0, 2'b00, -1, 1'b0, 19};
    vecs[9]  = '{1'b0, 8'hC0, 8'd15,  32'h55000000, 1'b0, 1'b1, 2'b00, -1, 1'b0, -1};
    vecs[10] = '{1'b1, 8'h00, 8'd255, 32'h77000000, 1'b0, 1'b0, 2'b00, -1, 1'b0, 259};
    vecs[11] = '{1'b0, 8'h00, 8'd255, 32'h77000000, 1'b0, 1'b0, 2'b00, -1, 1'b0, 258};

    // reset state
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_awvalid", axi.awvalid, 1'b0);
    chk("rst_arvalid", axi.arvalid, 1'b0);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // cmd_valid while busy: read stalled by rd_ready=0 must hold cmd_ready low
    rlast_at = 0; bresp_cfg = 2'b00;
    exp_rq.push_back(32'h77000000);
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h00; cmd_len = 8'd0; rd_ready = 0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmd_write = 1; cmd_addr = 8'h44;
      #1;
      chk("busy_cmd_ready", cmd_ready, 1'b0);
      chk("busy_flag", busy, 1'b1);
      chk("busy_no_aw", axi.awvalid, 1'b0);
    end
    @(negedge clk);
    cmd_valid = 0; rd_ready = 1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      #1;
      if (rd_valid && rd_ready) chk_pop_r(rd_data);
      if (done) begin seen = 1; chk("busy_seq_err", err, 1'b0); end
      else @(negedge clk);
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL busy_seq_timeout actual=none expected=done");
    end
    chk("busy_rq_left", exp_rq.size(), 0);
    exp_rq.delete();

    // reset during W beat 2: everything drops at once, no done afterwards
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h10; cmd_len = 8'd3; s_wready = 1;
    @(posedge clk);
    @(negedge clk);  // AW
    cmd_valid = 0; wr_valid = 1; wr_data = 32'hC0DE0000;
    @(negedge clk);  // W beat 0
    wr_data = 32'hC0DE0001;
    @(negedge clk);  // W beat 1
    wr_data = 32'hC0DE0002;
    @(negedge clk);  // W beat 2
    #1 chk("pre_rst_wr_ready", wr_ready, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cmd_ready", cmd_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_err", err, 1'b0);
    chk("arst_wr_ready", wr_ready, 1'b0);
    chk("arst_wvalid", axi.wvalid, 1'b0);
    chk("arst_wlast", axi.wlast, 1'b0);
    chk("arst_bready", axi.bready, 1'b0);
    chk("arst_rd_valid", rd_valid, 1'b0);
    chk("arst_rready", axi.rready, 1'b0);
    chk("arst_awvalid", axi.awvalid, 1'b0);
    chk("arst_arvalid", axi.arvalid, 1'b0);
    wr_valid = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_done", done, 1'b0);
      chk("post_rst_idle", busy, 1'b0);
    end
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
